// File: rtl/mixed_opcode_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mixed_opcode_dispatch                                      |
// | Description : Front-end command stage. Decodes raw 9-bit opcode words    |
// |               into {type, tag} and buffers legal ones in a FIFO. READ,   |
// |               WRITE, EVICT and TRIM are issued downstream. WAIT is run   |
// |               locally as a timed stall. Illegal types (5..7) are         |
// |               dropped and counted.                                       |
// | Ports       : clk, rst_n        - clock, async active-low reset          |
// |               cmd_valid/ready   - upstream handshake                     |
// |               cmd_opcode[8:0]   - raw opcode (type=[8:6], tag=[5:0])     |
// |               out_valid/ready   - downstream handshake                   |
// |               out_type[2:0]     - decoded opcode type                    |
// |               out_tag[5:0]      - decoded tag                            |
// |               busy              - FIFO non-empty or WAIT running         |
// |               err_pulse         - one-cycle pulse per illegal accept     |
// |               err_count         - saturating illegal-opcode count        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mixed_opcode_dispatch #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [8:0]       cmd_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_type,
  output logic [5:0]       out_tag,
  output logic             busy,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_WAIT  = 3'd2,
    OP_EVICT = 3'd3,
    OP_TRIM  = 3'd4
  } opcode_enum_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [5:0]    wait_cnt;
  state_t        state;
  state_t        state_next;

  logic          in_legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic [2:0]    head_type;
  logic [5:0]    head_tag;
  logic          fifo_empty;
  logic          wait_running;
  logic          can_issue;
  logic          head_is_wait;
  logic          wait_load;

  assign in_legal   = (cmd_opcode[8:6] <= OP_TRIM);
  // Ready is derived from the registered count only, so a pop while full
  // never opens a push slot in the same cycle. Held low during reset.
  assign cmd_ready  = rst_n && (count != FULL_CNT);
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && in_legal;

  assign head_type  = mem[rd_ptr][8:6];
  assign head_tag   = mem[rd_ptr][5:0];
  assign fifo_empty = (count == '0);

  // A WAIT whose counter has reached zero falls through to the head in the
  // same cycle, as does IDLE with a non-empty FIFO. This gives a WAIT with
  // tag n exactly n+1 cycles between its pop and the next emission.
  assign wait_running = (state == ST_WAIT) && (wait_cnt != 6'd0);
  assign can_issue    = !fifo_empty && !wait_running;
  assign head_is_wait = (head_type == OP_WAIT);
  assign wait_load    = can_issue && head_is_wait;
  assign pop          = can_issue && (head_is_wait || out_ready);

  assign busy = !fifo_empty || (state == ST_WAIT);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_type   = 3'd0;
    out_tag    = 6'd0;
    if (wait_running) begin
      state_next = ST_WAIT;
    end else if (can_issue) begin
      if (head_is_wait) begin
        state_next = ST_WAIT;
      end else begin
        out_valid  = 1'b1;
        out_type   = head_type;
        out_tag    = head_tag;
        state_next = (count_next != '0) ? ST_ISSUE : ST_IDLE;
      end
    end else begin
      state_next = ST_IDLE;
    end
  end

  // Payload storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_opcode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= 6'd0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wait_load) begin
        wait_cnt <= head_tag;
      end else if (wait_running) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      err_pulse <= accept && !in_legal;
      if (accept && !in_legal && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
